// File: rtl/keypad_scanner.sv
// keypad_scanner -- row-scanning 4x4 matrix keypad front end with debounce.
//
// Drives one keypad row low at a time. Each row is held for SCAN_DIV cycles
// and the synchronized column lines are sampled on the last cycle of that
// slot. A single active column captures the key and freezes the scan. The key
// must then stay stable for DEBOUNCE_CYCLES samples before it is reported.
// Release is debounced the same way before scanning resumes at the next row.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   col_n[3:0]  column sense, active-low, asynchronous to clk
//   row_n[3:0]  row drive, active-low, exactly one bit low
//   row_onehot  row of the accepted key (0 when no key is accepted)
//   col_onehot  column of the accepted key (0 when no key is accepted)
//   key_valid   high while the accepted key is held, including release debounce
//   key_pressed one-cycle pulse per accepted press
module keypad_scanner #(
   parameter int SCAN_DIV        = 24000,
   parameter int DEBOUNCE_CYCLES = 480000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] row_onehot,
   output logic [3:0] col_onehot,
   output logic       key_valid,
   output logic       key_pressed
);

   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DB_ONE    = DW'(1);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_PRESS_DB,
      ST_HELD,
      ST_RELEASE_DB
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_sync1, r_sync2;
   logic [1:0]      r_row_idx, w_row_idx_nxt;
   logic [SW-1:0]   r_slot, w_slot_nxt;
   logic [DW-1:0]   r_db, w_db_nxt;
   logic [1:0]      r_cap_col, w_cap_col_nxt;
   logic [3:0]      r_row_n;
   logic [3:0]      r_row_oh, w_row_oh_nxt;
   logic [3:0]      r_col_oh, w_col_oh_nxt;
   logic            r_valid, w_valid_nxt;
   logic            r_pressed, w_pressed_nxt;

   logic [3:0]      w_col_act;
   logic            w_single;
   logic [1:0]      w_col_enc;
   logic [3:0]      w_cap_oh;
   logic            w_cap_bit;

   assign w_col_act = ~r_sync2;
   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   assign w_single  = (w_col_act != 4'b0000) &&
                      ((w_col_act & (w_col_act - 4'b0001)) == 4'b0000);
   assign w_cap_oh  = 4'b0001 << r_cap_col;
   assign w_cap_bit = w_col_act[r_cap_col];

   always_comb begin
      w_col_enc = 2'd0;
      if      (w_col_act[0]) w_col_enc = 2'd0;
      else if (w_col_act[1]) w_col_enc = 2'd1;
      else if (w_col_act[2]) w_col_enc = 2'd2;
      else if (w_col_act[3]) w_col_enc = 2'd3;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_row_idx_nxt = r_row_idx;
      w_slot_nxt    = r_slot;
      w_db_nxt      = r_db;
      w_cap_col_nxt = r_cap_col;
      w_row_oh_nxt  = r_row_oh;
      w_col_oh_nxt  = r_col_oh;
      w_valid_nxt   = r_valid;
      w_pressed_nxt = 1'b0;

      unique case (r_state)
         ST_SCAN: begin
            if (r_slot == SLOT_LAST) begin
               w_slot_nxt = '0;
               if (w_single) begin
                  // Row index stays put so row_n keeps driving the captured row.
                  w_state_nxt   = ST_PRESS_DB;
                  w_cap_col_nxt = w_col_enc;
                  w_db_nxt      = DB_ONE;
               end else begin
                  w_row_idx_nxt = r_row_idx + 2'd1;
               end
            end else begin
               w_slot_nxt = r_slot + 1'b1;
            end
         end

         ST_PRESS_DB: begin
            if (w_col_act == w_cap_oh) begin
               if (r_db == DB_LAST) begin
                  w_state_nxt   = ST_HELD;
                  w_db_nxt      = '0;
                  w_pressed_nxt = 1'b1;
                  w_valid_nxt   = 1'b1;
                  w_row_oh_nxt  = 4'b0001 << r_row_idx;
                  w_col_oh_nxt  = w_cap_oh;
               end else begin
                  w_db_nxt = r_db + 1'b1;
               end
            end else begin
               w_state_nxt   = ST_SCAN;
               w_row_idx_nxt = r_row_idx + 2'd1;
               w_slot_nxt    = '0;
               w_db_nxt      = '0;
            end
         end

         ST_HELD: begin
            // Only the captured column matters; other keys are ignored.
            if (!w_cap_bit) begin
               w_state_nxt = ST_RELEASE_DB;
               w_db_nxt    = DB_ONE;
            end
         end

         ST_RELEASE_DB: begin
            if (w_cap_bit) begin
               w_state_nxt = ST_HELD;
               w_db_nxt    = '0;
            end else if (r_db == DB_LAST) begin
               w_state_nxt   = ST_SCAN;
               w_row_idx_nxt = r_row_idx + 2'd1;
               w_slot_nxt    = '0;
               w_db_nxt      = '0;
               w_valid_nxt   = 1'b0;
               w_row_oh_nxt  = 4'b0000;
               w_col_oh_nxt  = 4'b0000;
            end else begin
               w_db_nxt = r_db + 1'b1;
            end
         end

         default: w_state_nxt = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_SCAN;
         r_sync1   <= 4'b1111;
         r_sync2   <= 4'b1111;
         r_row_idx <= 2'd0;
         r_slot    <= '0;
         r_db      <= '0;
         r_cap_col <= 2'd0;
         r_row_n   <= 4'b1110;
         r_row_oh  <= 4'b0000;
         r_col_oh  <= 4'b0000;
         r_valid   <= 1'b0;
         r_pressed <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sync1   <= col_n;
         r_sync2   <= r_sync1;
         r_row_idx <= w_row_idx_nxt;
         r_slot    <= w_slot_nxt;
         r_db      <= w_db_nxt;
         r_cap_col <= w_cap_col_nxt;
         // Row drive is registered from the next row index so it moves in
         // lockstep with the scan position.
         r_row_n   <= ~(4'b0001 << w_row_idx_nxt);
         r_row_oh  <= w_row_oh_nxt;
         r_col_oh  <= w_col_oh_nxt;
         r_valid   <= w_valid_nxt;
         r_pressed <= w_pressed_nxt;
      end
   end

   assign row_n       = r_row_n;
   assign row_onehot  = r_row_oh;
   assign col_onehot  = r_col_oh;
   assign key_valid   = r_valid;
   assign key_pressed = r_pressed;

endmodule
